// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : aes_iter_core
// Description : Iterative AES-128 encryptor, one round per clock with
//               on-the-fly key expansion.
// Revision    : 1.0  initial release
// ============================================================================
module aes_iter_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Byte x of the table sits at bits [8x : 8x+7], MSB first.
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0]   state;
    logic [1:0]   next_state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   rn;

    logic [7:0]   sub_b   [16];
    logic [7:0]   shift_b [16];
    logic [7:0]   mix_b   [16];
    logic [127:0] shift_flat;
    logic [127:0] mix_flat;
    logic [31:0]  key_temp;
    logic [31:0]  nk0;
    logic [31:0]  nk1;
    logic [31:0]  nk2;
    logic [31:0]  nk3;
    logic [127:0] next_key;
    logic [127:0] round_full;
    logic [127:0] round_last;

    // Byte i is row i%4, column i/4; byte 0 occupies st[127:120].
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sub_b[i] = sbox(st[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_b[r+4*c] = sub_b[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c]   = xtime(shift_b[4*c]) ^ xtime(shift_b[4*c+1]) ^ shift_b[4*c+1]
                         ^ shift_b[4*c+2] ^ shift_b[4*c+3];
            mix_b[4*c+1] = shift_b[4*c] ^ xtime(shift_b[4*c+1]) ^ xtime(shift_b[4*c+2])
                         ^ shift_b[4*c+2] ^ shift_b[4*c+3];
            mix_b[4*c+2] = shift_b[4*c] ^ shift_b[4*c+1] ^ xtime(shift_b[4*c+2])
                         ^ xtime(shift_b[4*c+3]) ^ shift_b[4*c+3];
            mix_b[4*c+3] = xtime(shift_b[4*c]) ^ shift_b[4*c] ^ shift_b[4*c+1]
                         ^ shift_b[4*c+2] ^ xtime(shift_b[4*c+3]);
        end
        shift_flat = '0;
        mix_flat   = '0;
        for (int i = 0; i < 16; i++) begin
            shift_flat[127-8*i -: 8] = shift_b[i];
            mix_flat[127-8*i -: 8]   = mix_b[i];
        end
    end

    // Next round key derived from the current one: RotWord, SubWord, rcon.
    always_comb begin
        key_temp = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
                 ^ {rcon(rn), 24'h000000};
        nk0      = rk[127:96] ^ key_temp;
        nk1      = rk[95:64]  ^ nk0;
        nk2      = rk[63:32]  ^ nk1;
        nk3      = rk[31:0]   ^ nk2;
        next_key = {nk0, nk1, nk2, nk3};
    end

    assign round_full = mix_flat   ^ next_key;
    assign round_last = shift_flat ^ next_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = S_RUN;
            S_RUN:   if (rn == LAST_ROUND) next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_RUN);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
            rk <= '0;
            rn <= '0;
            ct <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st <= pt ^ key;
                        rk <= key;
                        rn <= 4'd1;
                    end else begin
                        rn <= 4'd0;
                    end
                end
                S_RUN: begin
                    rk <= next_key;
                    if (rn == LAST_ROUND) begin
                        st <= round_last;
                        ct <= round_last;
                        rn <= 4'd0;
                    end else begin
                        st <= round_full;
                        rn <= rn + 4'd1;
                    end
                end
                default: begin
                    rn <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_iter_core
// Description : Directed scoreboard bench for aes_iter_core (FIPS-197 vectors).
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_iter_core;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;
    logic         busy;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_t;

    sb_t          q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [127:0] cur_exp;
    logic         prev_ov = 1'b0;
    int           a1;
    int           a2;

    aes_iter_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt        (pt),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Handshakes are observed half a cycle ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                q.push_back('{exp: cur_exp, acc: cyc + 1});
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 128'(out_valid), 128'd0);
                end else begin
                    if (!prev_ov) chk("latency", 128'(cyc - q[0].acc), 128'd10);
                    chk("ct", ct, q[0].exp);
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_timeout", 128'(in_ready), 128'd1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("valid_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e);
        wait_ready();
        pt       = p;
        key      = k;
        cur_exp  = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pt       = {$urandom(), $urandom(), $urandom(), $urandom()};
        key      = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("run_busy", 128'(busy), 128'd1);
        chk("run_in_ready", 128'(in_ready), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt        = '0;
        key       = '0;
        cur_exp   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_ct", ct, 128'd0);
        rst = 1'b0;

        // Appendix B vector held under backpressure for 20 cycles.
        send(B_PT, B_KEY, B_CT);
        wait_valid();
        repeat (20) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", 128'(out_valid), 128'd0);
        chk("release_in_ready", 128'(in_ready), 128'd1);

        // Appendix C.1 vector.
        out_ready = 1'b1;
        send(C_PT, C_KEY, C_CT);
        wait_valid();
        @(posedge clk); #1;
        chk("c1_back_idle", 128'(in_ready), 128'd1);

        // in_valid pulse with other data during RUN cycle 5 must be ignored.
        send(B_PT, B_KEY, B_CT);
        repeat (4) @(posedge clk);
        #1;
        pt       = C_PT;
        key      = C_KEY;
        cur_exp  = C_CT;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1;
        repeat (15) @(posedge clk);
        #1;
        chk("ign_busy", 128'(busy), 128'd0);
        chk("ign_in_ready", 128'(in_ready), 128'd1);
        chk("ign_sb_empty", 128'(q.size()), 128'd0);

        // Reset during RUN cycle 4 aborts the block.
        out_ready = 1'b0;
        send(C_PT, C_KEY, C_CT);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_ct", ct, 128'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_out", 128'(out_valid), 128'd0);
        out_ready = 1'b1;
        send(C_PT, C_KEY, C_CT);
        wait_valid();
        @(posedge clk); #1;

        // Back-to-back with out_ready held high.
        wait_ready();
        pt       = B_PT;
        key      = B_KEY;
        cur_exp  = B_CT;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a1      = cyc;
        pt      = C_PT;
        key     = C_KEY;
        cur_exp = C_CT;
        wait_ready();
        @(posedge clk); #1;
        a2       = cyc;
        in_valid = 1'b0;
        chk("b2b_accept_gap", 128'(a2 - a1), 128'd12);
        wait_valid();
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_sb_drained", 128'(q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
